// File: rtl/t2mi_ts_pkg.sv
// Shared constants, enums and helpers for the T2-MI TS null stuffer.
package t2mi_ts_pkg;

  localparam int unsigned TS_PKT_LEN = 188;
  localparam logic [7:0]  TS_SYNC    = 8'h47;
  localparam logic [12:0] NULL_PID   = 13'h1FFF;
  localparam logic [7:0]  LAST_BYTE  = 8'(TS_PKT_LEN - 1);

  // Null header: TEI/PUSI/prio = 0, PID 0x1FFF, no scrambling, payload only, CC = 0.
  localparam logic [7:0] NULL_HDR1 = {3'b000, NULL_PID[12:8]};
  localparam logic [7:0] NULL_HDR2 = NULL_PID[7:0];
  localparam logic [7:0] NULL_HDR3 = 8'h10;

  typedef enum logic {SRC_FIFO, SRC_NULL} src_sel_e;

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DISCARD} wr_state_e;

  // Byte at position idx of a generated null packet.
  function automatic logic [7:0] null_byte(logic [7:0] idx, logic [7:0] fill);
    case (idx)
      8'd0:    null_byte = TS_SYNC;
      8'd1:    null_byte = NULL_HDR1;
      8'd2:    null_byte = NULL_HDR2;
      8'd3:    null_byte = NULL_HDR3;
      default: null_byte = fill;
    endcase
  endfunction

endpackage

// File: rtl/ts_slot_ram.sv
// Simple dual-port synchronous RAM, one-cycle read latency, inferred.
module ts_slot_ram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/t2mi_ts_null_stuffer.sv
// Packet-slot FIFO with null-packet stuffing for a constant-rate TS output.
// Optional statistics counters: define STUFF_STATS_EN.
module t2mi_ts_null_stuffer
  import t2mi_ts_pkg::*;
#(
  parameter int unsigned SLOT_W    = 2,
  parameter logic [7:0]  NULL_FILL = 8'hFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        ENA_IN,
  input  logic        PSYNC_IN,
  input  logic        BYTE_TICK,
  output logic [7:0]  DATA_OUT,
  output logic        ENA_OUT,
  output logic        PSYNC_OUT,
  output logic        FULL_OUT,
  output logic        DROP_OUT
`ifdef STUFF_STATS_EN
  ,
  output logic [31:0] NULL_CNT,
  output logic [31:0] DROP_CNT
`endif
);

  localparam logic [SLOT_W:0] CNT_FULL = {1'b1, {SLOT_W{1'b0}}};

  wr_state_e         w_state_q, w_state_d;
  logic [SLOT_W-1:0] wr_slot_q, rd_slot_q;
  logic [7:0]        wbyte_q, obyte_q;
  logic [SLOT_W:0]   count_q, count_d;
  logic              has_room, wr_en, wr_restart, commit, drop_d, release_pkt;
  logic [SLOT_W+7:0] wr_addr, rd_addr;
  logic [7:0]        ram_rdata;
  src_sel_e          src_q, src_cur, p1_src;
  logic              p1_valid, p1_sync;
  logic [7:0]        p1_null;

  assign has_room = (count_q != CNT_FULL);

  // Write FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) w_state_q <= W_IDLE;
    else      w_state_q <= w_state_d;
  end

  // Write FSM next state; a packet start in DISCARD is treated as in IDLE.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE, W_DISCARD: begin
        if (ENA_IN && PSYNC_IN) w_state_d = has_room ? W_WRITE : W_DISCARD;
      end
      W_WRITE: begin
        if (ENA_IN && !PSYNC_IN && wbyte_q == LAST_BYTE) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs: RAM write, restart at byte 0, commit and drop.
  always_comb begin
    wr_en      = 1'b0;
    wr_restart = 1'b0;
    commit     = 1'b0;
    drop_d     = 1'b0;
    if (w_state_q == W_WRITE) begin
      if (ENA_IN) begin
        wr_en = 1'b1;
        if (PSYNC_IN) begin
          drop_d     = 1'b1;
          wr_restart = 1'b1;
        end else if (wbyte_q == LAST_BYTE) begin
          commit = 1'b1;
        end
      end
    end else if (ENA_IN && PSYNC_IN) begin
      if (has_room) begin
        wr_en      = 1'b1;
        wr_restart = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  assign wr_addr = {wr_slot_q, (wr_restart ? 8'd0 : wbyte_q)};

  // Write byte counter and slot pointer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wbyte_q   <= 8'd0;
      wr_slot_q <= '0;
    end else if (commit) begin
      wbyte_q   <= 8'd0;
      wr_slot_q <= wr_slot_q + 1'b1;
    end else if (wr_en) begin
      wbyte_q <= wr_restart ? 8'd1 : wbyte_q + 8'd1;
    end
  end

  // Source is decided at byte 0 and held for the rest of the packet.
  assign src_cur     = (obyte_q == 8'd0) ? ((count_q != '0) ? SRC_FIFO : SRC_NULL) : src_q;
  assign release_pkt = BYTE_TICK && (obyte_q == LAST_BYTE) && (src_cur == SRC_FIFO);
  assign rd_addr     = {rd_slot_q, obyte_q};

  // Output byte counter, latched source and read slot pointer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      obyte_q   <= 8'd0;
      src_q     <= SRC_NULL;
      rd_slot_q <= '0;
    end else if (BYTE_TICK) begin
      obyte_q <= (obyte_q == LAST_BYTE) ? 8'd0 : obyte_q + 8'd1;
      src_q   <= src_cur;
      if (release_pkt) rd_slot_q <= rd_slot_q + 1'b1;
    end
  end

  // Committed-slot count; simultaneous commit and release cancel out.
  always_comb begin
    count_d = count_q;
    if (commit && !release_pkt)      count_d = count_q + 1'b1;
    else if (!commit && release_pkt) count_d = count_q - 1'b1;
  end

  // Slot count, full flag and drop pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q  <= '0;
      FULL_OUT <= 1'b0;
      DROP_OUT <= 1'b0;
    end else begin
      count_q  <= count_d;
      FULL_OUT <= (count_d == CNT_FULL);
      DROP_OUT <= drop_d;
    end
  end

  ts_slot_ram #(
    .AW (SLOT_W + 8),
    .DW (8)
  ) u_ram (
    .clk   (CLK),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (DATA_IN),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // Stage 1 runs alongside the RAM read so the null path has matching latency.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p1_valid <= 1'b0;
      p1_sync  <= 1'b0;
      p1_src   <= SRC_NULL;
      p1_null  <= 8'd0;
    end else begin
      p1_valid <= BYTE_TICK;
      p1_sync  <= (obyte_q == 8'd0);
      p1_src   <= src_cur;
      p1_null  <= null_byte(obyte_q, NULL_FILL);
    end
  end

  // Output register; DATA_OUT holds between ticks.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DATA_OUT  <= 8'd0;
      ENA_OUT   <= 1'b0;
      PSYNC_OUT <= 1'b0;
    end else begin
      ENA_OUT   <= p1_valid;
      PSYNC_OUT <= p1_valid && p1_sync;
      if (p1_valid) DATA_OUT <= (p1_src == SRC_FIFO) ? ram_rdata : p1_null;
    end
  end

`ifdef STUFF_STATS_EN
  logic null_start;
  assign null_start = BYTE_TICK && (obyte_q == 8'd0) && (count_q == '0);

  // Saturating statistics counters, cleared only by reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      NULL_CNT <= 32'd0;
      DROP_CNT <= 32'd0;
    end else begin
      if (null_start && NULL_CNT != 32'hFFFF_FFFF) NULL_CNT <= NULL_CNT + 32'd1;
      if (drop_d && DROP_CNT != 32'hFFFF_FFFF)     DROP_CNT <= DROP_CNT + 32'd1;
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_t2mi_ts_null_stuffer.sv
// Directed self-checking bench for t2mi_ts_null_stuffer (SLOT_W=2, NULL_FILL=FF).
module tb_t2mi_ts_null_stuffer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic       ENA_IN = 1'b0;
  logic       PSYNC_IN = 1'b0;
  logic       BYTE_TICK = 1'b0;
  logic [7:0] DATA_OUT;
  logic       ENA_OUT, PSYNC_OUT, FULL_OUT, DROP_OUT;
`ifdef STUFF_STATS_EN
  logic [31:0] NULL_CNT, DROP_CNT;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int drop_cycles = 0;
  int drop_mark;

  logic [7:0] q_data[$];
  logic       q_sync[$];

  t2mi_ts_null_stuffer dut (
    .CLK       (CLK),
    .RST       (RST),
    .DATA_IN   (DATA_IN),
    .ENA_IN    (ENA_IN),
    .PSYNC_IN  (PSYNC_IN),
    .BYTE_TICK (BYTE_TICK),
    .DATA_OUT  (DATA_OUT),
    .ENA_OUT   (ENA_OUT),
    .PSYNC_OUT (PSYNC_OUT),
    .FULL_OUT  (FULL_OUT),
    .DROP_OUT  (DROP_OUT)
`ifdef STUFF_STATS_EN
    ,
    .NULL_CNT  (NULL_CNT),
    .DROP_CNT  (DROP_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Capture the output stream and count drop-pulse cycles on the inactive edge.
  always @(negedge CLK) begin
    if (ENA_OUT) begin
      q_data.push_back(DATA_OUT);
      q_sync.push_back(PSYNC_OUT);
    end
    if (DROP_OUT) drop_cycles++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  function automatic logic [7:0] null_b(int i);
    case (i)
      0:       null_b = 8'h47;
      1:       null_b = 8'h1F;
      2:       null_b = 8'hFF;
      3:       null_b = 8'h10;
      default: null_b = 8'hFF;
    endcase
  endfunction

  // Test packet: 47 00 (64+id) 10, then (i + 7*id) for bytes 4..187.
  function automatic logic [7:0] pkt_b(int id, int i);
    case (i)
      0:       pkt_b = 8'h47;
      1:       pkt_b = 8'h00;
      2:       pkt_b = 8'(8'h64 + id);
      3:       pkt_b = 8'h10;
      default: pkt_b = 8'(i + 7 * id);
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pkt(string tag, int k, bit is_null, int id);
    int         bad = -1;
    int         idx;
    logic [7:0] exp_b, exp_bad, obs_b;
    logic       obs_s;
    exp_bad = 8'h00;
    obs_b   = 8'h00;
    obs_s   = 1'b0;
    for (int i = 0; i < 188; i++) begin
      idx   = k * 188 + i;
      exp_b = is_null ? null_b(i) : pkt_b(id, i);
      if (bad < 0) begin
        if (idx >= q_data.size()) begin
          bad = i;
          exp_bad = exp_b;
        end else if (q_data[idx] !== exp_b || q_sync[idx] !== (i == 0)) begin
          bad = i;
          exp_bad = exp_b;
          obs_b = q_data[idx];
          obs_s = q_sync[idx];
        end
      end
    end
    n_assert++;
    assert (bad < 0) else begin
      n_fail++;
      $error("FAIL %s: pkt %0d byte %0d observed %02h/sync %0b expected %02h/sync %0b",
             tag, k, bad, obs_b, obs_s, exp_bad, (bad == 0));
    end
  endtask

  task automatic tick_n(int n);
    @(posedge CLK);
    #1 BYTE_TICK = 1'b1;
    repeat (n) @(posedge CLK);
    #1 BYTE_TICK = 1'b0;
  endtask

  task automatic send_bytes(int id, int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      ENA_IN   = 1'b1;
      PSYNC_IN = (i == 0);
      DATA_IN  = pkt_b(id, i);
    end
  endtask

  task automatic send_pkt(int id);
    send_bytes(id, 188);
    @(posedge CLK);
    #1;
    ENA_IN   = 1'b0;
    PSYNC_IN = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state.
    #12;
    check("rst_data", DATA_OUT, 8'h00);
    check("rst_ena", ENA_OUT, 1'b0);
    check("rst_psync", PSYNC_OUT, 1'b0);
    check("rst_full", FULL_OUT, 1'b0);
    check("rst_drop", DROP_OUT, 1'b0);
`ifdef STUFF_STATS_EN
    check("rst_null_cnt", NULL_CNT, 32'd0);
    check("rst_drop_cnt", DROP_CNT, 32'd0);
`endif
    @(negedge CLK);
    RST = 1'b1;

    // Idle input: first byte appears two cycles after the first tick.
    @(posedge CLK);
    #1 BYTE_TICK = 1'b1;
    @(negedge CLK);
    check("lat_c0_ena", ENA_OUT, 1'b0);
    @(negedge CLK);
    check("lat_c1_ena", ENA_OUT, 1'b0);
    @(negedge CLK);
    check("lat_c2_ena", ENA_OUT, 1'b1);
    check("lat_c2_psync", PSYNC_OUT, 1'b1);
    check("lat_c2_data", DATA_OUT, 8'h47);
    repeat (374) @(posedge CLK);
    #1 BYTE_TICK = 1'b0;
    drain();
    check("idle_count", q_data.size(), 2 * 188);
    check_pkt("idle_null0", 0, 1'b1, 0);
    check_pkt("idle_null1", 1, 1'b1, 0);

    // Packet committed while a null packet is in flight.
    fork
      tick_n(4 * 188);
      begin
        repeat (12) @(posedge CLK);
        send_pkt(0);
      end
    join
    drain();
    check("mid_count", q_data.size(), 6 * 188);
    check_pkt("mid_null2", 2, 1'b1, 0);
    check_pkt("mid_null3", 3, 1'b1, 0);
    check_pkt("mid_data", 4, 1'b0, 0);
    check_pkt("mid_null5", 5, 1'b1, 0);

    // Overflow: four packets fill the buffer, the fifth is dropped.
    drop_mark = drop_cycles;
    send_pkt(1);
    send_pkt(2);
    send_pkt(3);
    check("ovf_full3", FULL_OUT, 1'b0);
    send_pkt(4);
    check("ovf_full4", FULL_OUT, 1'b1);
    check("ovf_nodrop4", drop_cycles - drop_mark, 0);
    send_pkt(5);
    drain();
    check("ovf_drop5", drop_cycles - drop_mark, 1);
    check("ovf_full5", FULL_OUT, 1'b1);
    tick_n(5 * 188);
    drain();
    check("ovf_full_after", FULL_OUT, 1'b0);
    check("ovf_count", q_data.size(), 11 * 188);
    check_pkt("ovf_p1", 6, 1'b0, 1);
    check_pkt("ovf_p2", 7, 1'b0, 2);
    check_pkt("ovf_p3", 8, 1'b0, 3);
    check_pkt("ovf_p4", 9, 1'b0, 4);
    check_pkt("ovf_null", 10, 1'b1, 0);

    // Truncation: new PSYNC at byte 100 abandons the partial packet.
    drop_mark = drop_cycles;
    send_bytes(6, 100);
    send_pkt(7);
    drain();
    check("trunc_drop", drop_cycles - drop_mark, 1);
    tick_n(2 * 188);
    drain();
    check("trunc_count", q_data.size(), 13 * 188);
    check_pkt("trunc_p7", 11, 1'b0, 7);
    check_pkt("trunc_null", 12, 1'b1, 0);

    // Commit and release on the same edge with two packets buffered.
    send_pkt(8);
    send_pkt(9);
    fork
      tick_n(4 * 188);
      send_pkt(10);
    join
    drain();
    check("coinc_full", FULL_OUT, 1'b0);
    check("coinc_count", q_data.size(), 17 * 188);
    check_pkt("coinc_p8", 13, 1'b0, 8);
    check_pkt("coinc_p9", 14, 1'b0, 9);
    check_pkt("coinc_p10", 15, 1'b0, 10);
    check_pkt("coinc_null", 16, 1'b1, 0);

    // Asynchronous reset mid-packet on both sides.
    send_pkt(12);
    send_pkt(13);
    send_pkt(14);
    @(posedge CLK);
    #1 BYTE_TICK = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ENA_IN   = 1'b1;
      PSYNC_IN = (i == 0);
      DATA_IN  = pkt_b(15, i);
      @(posedge CLK);
      #1;
    end
    #2;
    check("pre_rst_ena", ENA_OUT, 1'b1);
    RST = 1'b0;
    #1;
    check("arst_data", DATA_OUT, 8'h00);
    check("arst_ena", ENA_OUT, 1'b0);
    check("arst_psync", PSYNC_OUT, 1'b0);
    check("arst_full", FULL_OUT, 1'b0);
    check("arst_drop", DROP_OUT, 1'b0);
    BYTE_TICK = 1'b0;
    ENA_IN    = 1'b0;
    PSYNC_IN  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
`ifdef STUFF_STATS_EN
    check("arst_null_cnt", NULL_CNT, 32'd0);
    check("arst_drop_cnt", DROP_CNT, 32'd0);
`endif
    RST = 1'b1;
    q_data.delete();
    q_sync.delete();
    tick_n(2 * 188);
    drain();
    check("post_rst_count", q_data.size(), 2 * 188);
    check_pkt("post_rst_null0", 0, 1'b1, 0);
    check_pkt("post_rst_null1", 1, 1'b1, 0);
`ifdef STUFF_STATS_EN
    check("post_rst_null_cnt", NULL_CNT, 32'd2);
    send_pkt(16);
    send_pkt(17);
    send_pkt(18);
    send_pkt(19);
    send_pkt(20);
    drain();
    check("post_rst_drop_cnt", DROP_CNT, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
